pwm_duty_ramp: RTL and testbench

Slew-rate limiter placed directly upstream of the PWM core. It takes a raw 7-bit duty-cycle target from the input pins, synchronizes it, and walks the duty word it drives into the PWM `dc` input toward that target in bounded steps. This gives soft-start and soft-stop, so a pin change never makes the PWM output jump.

---
 rtl/pwm_duty_ramp_if.sv | 12 +
 rtl/pwm_duty_ramp.sv | 105 ++++++++++
 tb/tb_pwm_duty_ramp.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_duty_ramp_if.sv
// Handshake bundle between the duty-ramp limiter and its neighbours.
// The master side drives the raw target and the freeze request; the slave side is the limiter.
interface pwm_duty_ramp_if;
  logic [6:0] target;
  logic       freeze;
  logic [6:0] dc;
  logic       busy;
  logic       at_target;

  modport master (output target, freeze, input dc, busy, at_target);
  modport slave  (input target, freeze, output dc, busy, at_target);
endinterface

// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter feeding the PWM duty input: walks dc toward a synchronized target in bounded steps.
// Optional macro DUTY_RAMP_CLAMP_EN limits the effective target to 100.
module pwm_duty_ramp #(
  parameter int unsigned STEP_CYCLES = 1000,
  parameter int unsigned STEP_SIZE   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  pwm_duty_ramp_if.slave  bus
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_UP     = 2'd1;
  localparam logic [1:0]  S_DOWN   = 2'd2;
  localparam logic [15:0] CNT_LAST = 16'(STEP_CYCLES - 1);
  localparam logic [7:0]  STEP_W   = 8'(STEP_SIZE);

  logic [6:0]  t_s1;
  logic [6:0]  t_s2;
  logic [6:0]  tgt;
  logic [6:0]  dc;
  logic [6:0]  dc_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  dir;
  logic        busy;
  logic        at_target;

  function automatic logic [6:0] clamp_tgt(input logic [6:0] t);
`ifdef DUTY_RAMP_CLAMP_EN
    return (t > 7'd100) ? 7'd100 : t;
`else
    return t;
`endif
  endfunction

  function automatic logic [1:0] dir_of(input logic [6:0] cur, input logic [6:0] goal);
    if (cur < goal)      return S_UP;
    else if (cur > goal) return S_DOWN;
    else                 return S_IDLE;
  endfunction

  // Move by STEP_SIZE but never past the goal; 8-bit unsigned magnitudes avoid any wrap.
  function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] goal);
    logic [7:0] diff;
    logic [7:0] mv;
    if (goal > cur) diff = {1'b0, goal} - {1'b0, cur};
    else            diff = {1'b0, cur} - {1'b0, goal};
    mv = (diff < STEP_W) ? diff : STEP_W;
    if (goal > cur) return 7'({1'b0, cur} + mv);
    else            return 7'({1'b0, cur} - mv);
  endfunction

  always_comb begin
    tgt       = clamp_tgt(t_s2);
    dir       = dir_of(dc, tgt);
    dc_nxt    = dc;
    cnt_nxt   = cnt;
    state_nxt = state;
    if (!bus.freeze) begin
      if (dir == S_IDLE) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end else if (state == S_IDLE) begin
        state_nxt = dir;
        cnt_nxt   = '0;
      end else if (cnt == CNT_LAST) begin
        // A reversal keeps cnt running, so the step cadence is never disturbed.
        cnt_nxt   = '0;
        dc_nxt    = step_toward(dc, tgt);
        state_nxt = dir_of(dc_nxt, tgt);
      end else begin
        cnt_nxt   = cnt + 16'd1;
        state_nxt = dir;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_s1      <= '0;
      t_s2      <= '0;
      state     <= S_IDLE;
      cnt       <= '0;
      dc        <= '0;
      busy      <= 1'b0;
      at_target <= 1'b1;
    end else begin
      t_s1      <= bus.target;
      t_s2      <= t_s1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      dc        <= dc_nxt;
      if (!bus.freeze) busy <= (state_nxt != S_IDLE);
      at_target <= (dc_nxt == tgt);
    end
  end

  assign bus.dc        = dc;
  assign bus.busy      = busy;
  assign bus.at_target = at_target;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed sequences, a vector table and a randomized run against a behavioural model.
module tb_pwm_duty_ramp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_duty_ramp_if ifa ();
  pwm_duty_ramp_if ifb ();
  pwm_duty_ramp_if ifc ();
  pwm_duty_ramp_if ifd ();
  pwm_duty_ramp_if ifr ();

  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP_SIZE(1))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP_SIZE(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP_SIZE(4))  dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP_SIZE(1))  dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));
  pwm_duty_ramp #(.STEP_CYCLES(5), .STEP_SIZE(3))  dut_r (.clk(clk), .rst_n(rst_n), .bus(ifr.slave));

  localparam int R_SC = 5;
  localparam int R_SS = 3;

  typedef struct {
    int sel;
    int tgt;
    int wait_n;
    int dc;
    int busy;
    int at;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int clampt(input int t);
`ifdef DUTY_RAMP_CLAMP_EN
    return (t > 100) ? 100 : t;
`else
    return t;
`endif
  endfunction

  vec_t vecs[$];

  initial begin
    int n;
    int exp_top;
    int m_s1, m_s2, m_dc, m_el, tg, d, mv, cur_t;
    bit m_ramp, m_busy, fr;

    // B ramps 0x50 -> 0x10 by 16; C ramps 0x00 -> 0x05 by 4 (final step limited).
    vecs.push_back('{0, 16, 3, 80, 1, 0});
    vecs.push_back('{0, 16, 3, 80, 1, 0});
    vecs.push_back('{0, 16, 1, 64, 1, 0});
    vecs.push_back('{0, 16, 3, 64, 1, 0});
    vecs.push_back('{0, 16, 1, 48, 1, 0});
    vecs.push_back('{0, 16, 4, 32, 1, 0});
    vecs.push_back('{0, 16, 4, 16, 0, 1});
    vecs.push_back('{0, 16, 8, 16, 0, 1});
    vecs.push_back('{1, 5,  3, 0,  1, 0});
    vecs.push_back('{1, 5,  4, 4,  1, 0});
    vecs.push_back('{1, 5,  3, 4,  1, 0});
    vecs.push_back('{1, 5,  1, 5,  0, 1});
    vecs.push_back('{1, 5,  10, 5, 0, 1});

    ifa.target = 7'h50; ifa.freeze = 1'b0;
    ifb.target = 7'h50; ifb.freeze = 1'b0;
    ifc.target = 7'h00; ifc.freeze = 1'b0;
    ifd.target = 7'h00; ifd.freeze = 1'b0;
    ifr.target = 7'h00; ifr.freeze = 1'b0;

    // Reset held, then soft-start to 0x50 at one LSB per 4 clocks
    tick(3);
    check("rst_dc", ifa.dc, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_at", ifa.at_target, 1);
    rst_n = 1'b1;
    tick(2);
    check("start_busy_e2", ifa.busy, 0);
    tick(1);
    check("start_busy_e3", ifa.busy, 1);
    check("start_at_e3", ifa.at_target, 0);
    tick(319);
    check("start_dc_e322", ifa.dc, 8'h4F);
    check("start_busy_e322", ifa.busy, 1);
    tick(1);
    check("start_dc_e323", ifa.dc, 8'h50);
    check("start_busy_e323", ifa.busy, 0);
    check("start_at_e323", ifa.at_target, 1);
    check("b_idle_dc", ifb.dc, 8'h50);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].sel == 0) ifb.target = 7'(vecs[i].tgt);
      else                  ifc.target = 7'(vecs[i].tgt);
      tick(vecs[i].wait_n);
      if (vecs[i].sel == 0) begin
        check($sformatf("vec%0d_dc", i), ifb.dc, vecs[i].dc);
        check($sformatf("vec%0d_busy", i), ifb.busy, vecs[i].busy);
        check($sformatf("vec%0d_at", i), ifb.at_target, vecs[i].at);
      end else begin
        check($sformatf("vec%0d_dc", i), ifc.dc, vecs[i].dc);
        check($sformatf("vec%0d_busy", i), ifc.busy, vecs[i].busy);
        check($sformatf("vec%0d_at", i), ifc.at_target, vecs[i].at);
      end
    end

    // Clamp: 0x7F settles at 0x64 only when the clamp is built in
`ifdef DUTY_RAMP_CLAMP_EN
    exp_top = 100;
`else
    exp_top = 127;
`endif
    ifc.target = 7'h7F;
    tick(3 + 4 * 31 + 6);
    check("clamp_dc", ifc.dc, exp_top);
    check("clamp_at", ifc.at_target, 1);
    check("clamp_busy", ifc.busy, 0);

    // Reversal: ramping up to 0x40, retarget to 0x18 right after dc reaches 0x20
    ifd.target = 7'h40;
    n = 0;
    while (ifd.dc !== 7'h20 && n < 400) begin
      tick(1);
      n++;
    end
    check("rev_reach_t", n, 131);
    ifd.target = 7'h18;
    n = 0;
    while (ifd.dc === 7'h20 && n < 10) begin
      tick(1);
      n++;
    end
    check("rev_step_t", n, 4);
    check("rev_step_dc", ifd.dc, 8'h1F);
    check("rev_busy", ifd.busy, 1);
    tick(27);
    check("rev_dc_pre", ifd.dc, 8'h19);
    tick(1);
    check("rev_end_dc", ifd.dc, 8'h18);
    check("rev_end_busy", ifd.busy, 0);
    check("rev_end_at", ifd.at_target, 1);

    // Freeze for 20 clocks two cycles after a step: remaining spacing is 2 clocks
    ifa.target = 7'h40;
    n = 0;
    while (ifa.dc === 7'h50 && n < 20) begin
      tick(1);
      n++;
    end
    check("frz_first_t", n, 7);
    check("frz_first_dc", ifa.dc, 8'h4F);
    tick(2);
    ifa.freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check($sformatf("frz_hold_dc%0d", i), ifa.dc, 8'h4F);
      check($sformatf("frz_hold_busy%0d", i), ifa.busy, 1);
    end
    ifa.freeze = 1'b0;
    tick(1);
    check("frz_resume1", ifa.dc, 8'h4F);
    tick(1);
    check("frz_resume2", ifa.dc, 8'h4E);
    tick(4);
    check("frz_resume6", ifa.dc, 8'h4D);

    // Randomized run on dut_r against a behavioural model
    m_s1 = 0; m_s2 = 0; m_dc = 0; m_el = 0; m_ramp = 0; m_busy = 0;
    cur_t = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 1) == 0) cur_t = int'($urandom_range(0, 127));
        else begin
          cur_t = m_dc + int'($urandom_range(0, 10)) - 5;
          if (cur_t < 0) cur_t = 0;
          if (cur_t > 127) cur_t = 127;
        end
      end
      fr = ($urandom_range(0, 9) == 0);
      ifr.target = 7'(cur_t);
      ifr.freeze = fr;
      tick(1);
      tg = clampt(m_s2);
      if (!fr) begin
        if (m_dc == tg) begin
          m_ramp = 0;
          m_el = 0;
        end else if (!m_ramp) begin
          m_ramp = 1;
          m_el = 0;
        end else begin
          m_el++;
          if (m_el == R_SC) begin
            m_el = 0;
            d  = tg - m_dc;
            mv = (d < 0) ? -d : d;
            if (mv > R_SS) mv = R_SS;
            m_dc = (d > 0) ? m_dc + mv : m_dc - mv;
            if (m_dc == tg) m_ramp = 0;
          end
        end
        m_busy = m_ramp;
      end
      m_s2 = m_s1;
      m_s1 = cur_t;
      check($sformatf("rnd%0d_dc", cyc), ifr.dc, m_dc);
      check($sformatf("rnd%0d_busy", cyc), ifr.busy, m_busy);
      check($sformatf("rnd%0d_at", cyc), ifr.at_target, (m_dc == tg) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
